// File: rtl/risc_ctrl_pkg.sv
// Shared opcode constants, state encoding and instruction classes for the
// control unit and the datapath ALU decode.
package risc_ctrl_pkg;

    localparam int OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

    // Control sequencer states. DEFAULT is the post-reset idle state.
    typedef enum logic [3:0] {
        ST_DEFAULT = 4'd0,
        ST_T0      = 4'd1,
        ST_T1      = 4'd2,
        ST_T2      = 4'd3,
        ST_T3      = 4'd4,
        ST_T4      = 4'd5,
        ST_T5      = 4'd6,
        ST_T6      = 4'd7,
        ST_T7      = 4'd8,
        ST_HALT    = 4'd9
    } state_t;

    // Instruction classes. Undefined opcodes fold into CLS_NOP so they
    // simply fall back to the next fetch.
    typedef enum logic [2:0] {
        CLS_LOAD  = 3'd0,
        CLS_LOADI = 3'd1,
        CLS_STORE = 3'd2,
        CLS_ALU_R = 3'd3,
        CLS_ALU_I = 3'd4,
        CLS_NOP   = 3'd5,
        CLS_HALT  = 3'd6
    } op_class_t;

endpackage

// File: rtl/op_class_decode.sv
// Maps the 5-bit opcode field to an instruction class for the sequencer.
module op_class_decode
    import risc_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    output op_class_t           o_class
);

    // Pure lookup; anything not recognised behaves as a no-op.
    always_comb begin
        o_class = CLS_NOP;
        case (i_opcode)
            OP_LD:                   o_class = CLS_LOAD;
            OP_LDI:                  o_class = CLS_LOADI;
            OP_ST:                   o_class = CLS_STORE;
            OP_ADD, OP_SUB,
            OP_AND, OP_OR:           o_class = CLS_ALU_R;
            OP_ADDI, OP_ANDI,
            OP_ORI:                  o_class = CLS_ALU_I;
            OP_HALT:                 o_class = CLS_HALT;
            default:                 o_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch (T0..T2), execute (T3..T7), halt.
// Outputs are a combinational function of the current state and opcode.
// Memory handshake: Read/Write stay asserted and the state holds until
// Mem_ready is sampled high at a rising clock edge; that edge completes
// the access and advances the sequence.
module control_unit
    import risc_ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        Mem_ready,
    output logic        PCout, Zhighout, Zlowout, MDRout, HIout,
    output logic        LOout, InPortout, Cout, BAout,
    output logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin,
    output logic        IRin, OutPortin, CONin,
    output logic        Gra, Grb, Grc, Rin, Rout,
    output logic        IncPC, Read, Write,
    output logic        Run,
    output state_t      o_dbg_state
);

    state_t    r_state;
    state_t    w_next_state;
    op_class_t w_class;
    logic      w_unused;

    // Only the opcode field drives sequencing.
    assign w_unused = ^IR[26:0];

    op_class_decode u_decode (
        .i_opcode (IR[31:27]),
        .o_class  (w_class)
    );

    assign o_dbg_state = r_state;

    // State register with synchronous reset to DEFAULT.
    always_ff @(posedge Clock) begin
        if (Reset) r_state <= ST_DEFAULT;
        else       r_state <= w_next_state;
    end

    // Next-state and control outputs; everything defaults low.
    always_comb begin
        w_next_state = r_state;
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout} = '0;
        {PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin} = '0;
        {Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, Run} = '0;
        case (r_state)
            ST_DEFAULT: w_next_state = ST_T0;
            ST_T0: begin
                Run = 1'b1;
                {PCout, MARin, IncPC, Zin} = '1;
                w_next_state = ST_T1;
            end
            ST_T1: begin
                Run = 1'b1;
                {Zlowout, PCin, Read, MDRin} = '1;
                if (Mem_ready) w_next_state = ST_T2;
            end
            ST_T2: begin
                Run = 1'b1;
                {MDRout, IRin} = '1;
                w_next_state = ST_T3;
            end
            ST_T3: begin
                Run = 1'b1;
                case (w_class)
                    CLS_LOAD, CLS_LOADI, CLS_STORE: begin
                        {Grb, BAout, Yin} = '1;
                        w_next_state = ST_T4;
                    end
                    CLS_ALU_R, CLS_ALU_I: begin
                        {Grb, Rout, Yin} = '1;
                        w_next_state = ST_T4;
                    end
                    CLS_HALT: w_next_state = ST_HALT;
                    default:  w_next_state = ST_T0;
                endcase
            end
            ST_T4: begin
                Run = 1'b1;
                w_next_state = ST_T5;
                case (w_class)
                    CLS_LOAD, CLS_LOADI, CLS_STORE, CLS_ALU_I: {Cout, Zin} = '1;
                    CLS_ALU_R: {Grc, Rout, Zin} = '1;
                    default:   w_next_state = ST_T0;
                endcase
            end
            ST_T5: begin
                Run = 1'b1;
                w_next_state = ST_T0;
                case (w_class)
                    CLS_LOADI, CLS_ALU_R, CLS_ALU_I: {Zlowout, Gra, Rin} = '1;
                    CLS_LOAD, CLS_STORE: begin
                        {Zlowout, MARin} = '1;
                        w_next_state = ST_T6;
                    end
                    default: w_next_state = ST_T0;
                endcase
            end
            ST_T6: begin
                Run = 1'b1;
                w_next_state = ST_T0;
                case (w_class)
                    CLS_LOAD: begin
                        {Read, MDRin} = '1;
                        w_next_state = Mem_ready ? ST_T7 : ST_T6;
                    end
                    CLS_STORE: begin
                        {Gra, Rout, MDRin} = '1;
                        w_next_state = ST_T7;
                    end
                    default: w_next_state = ST_T0;
                endcase
            end
            ST_T7: begin
                Run = 1'b1;
                w_next_state = ST_T0;
                case (w_class)
                    CLS_LOAD: {MDRout, Gra, Rin} = '1;
                    CLS_STORE: begin
                        Write = 1'b1;
                        w_next_state = Mem_ready ? ST_T0 : ST_T7;
                    end
                    default: w_next_state = ST_T0;
                endcase
            end
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_DEFAULT;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a micro-program reference model (per-opcode list
// of expected control sets, with memory-wait steps) compared cycle by cycle.
module tb_control_unit;
    import risc_ctrl_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] IR;
    logic        Mem_ready;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout;
    logic PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin;
    logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, Run;
    state_t o_dbg_state;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Mem_ready(Mem_ready),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
        .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .IRin(IRin), .OutPortin(OutPortin), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .IncPC(IncPC), .Read(Read), .Write(Write), .Run(Run),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset block
    always #5 Clock = ~Clock;

    // Observed controls packed into one vector, bit 0 = PCout.
    logic [27:0] w_obs;
    assign w_obs = {Run, Write, Read, IncPC, Rout, Rin, Grc, Grb, Gra, CONin, OutPortin,
                    IRin, LOin, HIin, Yin, MARin, MDRin, Zin, PCin, BAout, Cout,
                    InPortout, LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

    localparam logic [27:0] M_PCOUT   = 28'd1 << 0;
    localparam logic [27:0] M_ZLOWOUT = 28'd1 << 2;
    localparam logic [27:0] M_MDROUT  = 28'd1 << 3;
    localparam logic [27:0] M_COUT    = 28'd1 << 7;
    localparam logic [27:0] M_BAOUT   = 28'd1 << 8;
    localparam logic [27:0] M_PCIN    = 28'd1 << 9;
    localparam logic [27:0] M_ZIN     = 28'd1 << 10;
    localparam logic [27:0] M_MDRIN   = 28'd1 << 11;
    localparam logic [27:0] M_MARIN   = 28'd1 << 12;
    localparam logic [27:0] M_YIN     = 28'd1 << 13;
    localparam logic [27:0] M_IRIN    = 28'd1 << 16;
    localparam logic [27:0] M_GRA     = 28'd1 << 19;
    localparam logic [27:0] M_GRB     = 28'd1 << 20;
    localparam logic [27:0] M_GRC     = 28'd1 << 21;
    localparam logic [27:0] M_RIN     = 28'd1 << 22;
    localparam logic [27:0] M_ROUT    = 28'd1 << 23;
    localparam logic [27:0] M_INCPC   = 28'd1 << 24;
    localparam logic [27:0] M_READ    = 28'd1 << 25;
    localparam logic [27:0] M_WRITE   = 28'd1 << 26;
    localparam logic [27:0] M_RUN     = 28'd1 << 27;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt_read, cnt_write, cnt_incpc, cnt_cycles;
    int fixed_wait[8];
    bit use_fixed;

    // reference micro-program for the current instruction
    logic [27:0] prog_ctl[$];
    bit          prog_wait[$];

    function automatic state_t t_state(input int i);
        case (i)
            0: return ST_T0;  1: return ST_T1;  2: return ST_T2;  3: return ST_T3;
            4: return ST_T4;  5: return ST_T5;  6: return ST_T6;  7: return ST_T7;
            default: return ST_DEFAULT;
        endcase
    endfunction

    task automatic push(input logic [27:0] ctl, input bit w);
        prog_ctl.push_back(ctl | M_RUN);
        prog_wait.push_back(w);
    endtask

    task automatic build(input logic [4:0] op);
        prog_ctl.delete();
        prog_wait.delete();
        push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 1'b0);
        push(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 1'b1);
        push(M_MDROUT | M_IRIN, 1'b0);
        case (op)
            5'b00000: begin
                push(M_GRB | M_BAOUT | M_YIN, 0); push(M_COUT | M_ZIN, 0);
                push(M_ZLOWOUT | M_MARIN, 0); push(M_READ | M_MDRIN, 1);
                push(M_MDROUT | M_GRA | M_RIN, 0);
            end
            5'b00001: begin
                push(M_GRB | M_BAOUT | M_YIN, 0); push(M_COUT | M_ZIN, 0);
                push(M_ZLOWOUT | M_GRA | M_RIN, 0);
            end
            5'b00010: begin
                push(M_GRB | M_BAOUT | M_YIN, 0); push(M_COUT | M_ZIN, 0);
                push(M_ZLOWOUT | M_MARIN, 0); push(M_GRA | M_ROUT | M_MDRIN, 0);
                push(M_WRITE, 1);
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                push(M_GRB | M_ROUT | M_YIN, 0); push(M_GRC | M_ROUT | M_ZIN, 0);
                push(M_ZLOWOUT | M_GRA | M_RIN, 0);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                push(M_GRB | M_ROUT | M_YIN, 0); push(M_COUT | M_ZIN, 0);
                push(M_ZLOWOUT | M_GRA | M_RIN, 0);
            end
            default: push(28'd0, 0);   // nop, halt and undefined: empty T3
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic mr);
        Mem_ready = mr;
        @(posedge Clock);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [27:0] exp_ctl, input state_t exp_st);
        chk({tag, "_ctl"}, {4'd0, w_obs}, {4'd0, exp_ctl});
        chk({tag, "_state"}, {28'd0, o_dbg_state}, {28'd0, exp_st});
        if (w_obs[24]) cnt_incpc++;
        if (w_obs[25]) cnt_read++;
        if (w_obs[26]) cnt_write++;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc(1'($urandom_range(0, 1)));
        check_now("reset", 28'd0, ST_DEFAULT);
        Reset = 1'b0;
        cyc(1'($urandom_range(0, 1)));
    endtask

    // Runs one instruction from T0; abort_at >= 0 pulses Reset in that step.
    task automatic run_instr(input logic [31:0] ir, input int abort_at);
        build(ir[31:27]);
        cnt_read = 0; cnt_write = 0; cnt_incpc = 0; cnt_cycles = 0;
        for (int idx = 0; idx < prog_ctl.size(); idx++) begin
            int  waits;
            bit  stay;
            waits = prog_wait[idx] ? (use_fixed ? fixed_wait[idx] : int'($urandom_range(0, 3))) : 0;
            stay = 1'b1;
            while (stay) begin
                cnt_cycles++;
                check_now($sformatf("op%0h_T%0d", ir[31:27], idx), prog_ctl[idx], t_state(idx));
                if (idx == abort_at) begin
                    Reset = 1'b1;
                    cyc(1'($urandom_range(0, 1)));
                    check_now("abort_reset", 28'd0, ST_DEFAULT);
                    Reset = 1'b0;
                    cyc(1'b1);
                    return;
                end
                // garbage IR during fetch must not disturb sequencing
                if (idx < 2) IR = $urandom; else IR = ir;
                if (waits > 0) begin
                    waits--;
                    cyc(1'b0);
                end else begin
                    cyc(prog_wait[idx] ? 1'b1 : 1'($urandom_range(0, 1)));
                    stay = 1'b0;
                end
            end
        end
    endtask

    logic [4:0] ops[12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                            5'b00110, 5'b01100, 5'b01101, 5'b01110, 5'b11010, 5'b11011};

    initial begin
        Reset = 1'b1; Mem_ready = 1'b0; IR = 32'd0;
        use_fixed = 1'b1;
        foreach (fixed_wait[i]) fixed_wait[i] = 0;

        do_reset();

        // addi: 6 cycles back to T0
        run_instr(32'h611FFFFD, -1);
        chk("addi_cycles", cnt_cycles, 6);

        // ld: 8 cycles
        run_instr(32'h00800075, -1);
        chk("ld_cycles", cnt_cycles, 8);

        // fetch wait of 3 cycles on an add
        fixed_wait[1] = 3;
        run_instr(32'h18000000 | $urandom_range(0, 32'h07FFFFFF), -1);
        chk("fetch_read_cycles", cnt_read, 4);
        chk("fetch_incpc_cycles", cnt_incpc, 1);
        fixed_wait[1] = 0;

        // st with 2 wait cycles in T7
        fixed_wait[7] = 2;
        run_instr(32'h10800075, -1);
        chk("st_write_cycles", cnt_write, 3);
        chk("st_incpc_cycles", cnt_incpc, 1);
        fixed_wait[7] = 0;

        // reset in the middle of a ld (T5), fetch restarts
        run_instr(32'h00800075, 5);

        // randomized instruction stream with random memory waits
        use_fixed = 1'b0;
        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            if ($urandom_range(0, 4) == 0) op = 5'($urandom);
            else op = ops[$urandom_range(0, 10)];
            if (op == 5'b11011) op = 5'b11010;
            run_instr({op, 27'($urandom)}, -1);
            chk("rand_incpc_once", cnt_incpc, 1);
        end

        // halt, then stay quiet for 20 cycles until reset
        run_instr(32'hD8000000, -1);
        for (int n = 0; n < 20; n++) begin
            check_now("halt", 28'd0, ST_HALT);
            IR = $urandom;
            cyc(1'($urandom_range(0, 1)));
        end
        do_reset();
        run_instr(32'hD0000000, -1);   // nop after restart
        check_now("post_nop_T0", M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN, ST_T0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
